mio_arbiter: RTL and testbench
==============================

# mio_arbiter

Two-master, one-slave memory/IO bus arbiter for the multicycle CPU system. It shares a single fixed-latency memory port between the CPU (master 0, driven from `CPU_MIO`/`mem_w`/`Addr_out`/`Data_out` and returning `MIO_ready`/`Data_in`) and a second bus master such as DMA or a display fetch unit (master 1). It latches the winning request, holds the memory port for `LAT` cycles, registers the read data and returns a one-cycle ready pulse. Arbitration is round-robin.

## Interface
Parameters:
- `LAT`, 2: memory access cycles from issue to `mem_rdata` valid; must be ≥ 1.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  CPU request level; held until `m0_ready`.
- `m0_we`  in  1  CPU write enable (1 = write).
- `m0_addr`  in  AW  CPU address.
- `m0_wdata`  in  DW  CPU write data.
- `m0_ready`  out  1  one-cycle completion pulse to the CPU.
- `m0_rdata`  out  DW  CPU read data; valid when `m0_ready` = 1, held afterwards.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ready`, `m1_rdata`: same as m0, for master 1.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  latched address.
- `mem_wdata`  out  DW  latched write data.
- `mem_rdata`  in  DW  memory read data; valid on the last ACCESS cycle.
- `grant`  out  2  one-hot owner during ACCESS/RESP: 01 = m0, 10 = m1, 00 = idle.

## Operation
- FSM states:
  - IDLE: no transaction.
  - ACCESS: the memory port is driven.
  - RESP: the ready pulse is returned.
- IDLE → ACCESS when either request is high. On that edge the arbiter latches the owner plus that master's `we`, `addr` and `wdata`, and loads the counter with `LAT-1`.
- ACCESS:
  - `mem_en` = 1.
  - `mem_we` = latched `we`, held for all `LAT` cycles; the address and data do not change, so repeated writes are idempotent.
  - The counter decrements each cycle.
  - When the counter is 0: capture `mem_rdata` into the owner's rdata register (reads only) and go to RESP.
- RESP: owner's `ready` = 1 for exactly one cycle, then IDLE. A master whose `req` is still high in IDLE is treated as issuing a new transaction.
- Round-robin arbitration:
  - Register `last` resets to 1 (m1), so m0 wins the first simultaneous request.
  - With both `req` high in IDLE, grant the master ≠ `last`.
  - With a single `req` high, grant it regardless of `last`.
  - Update `last` on every grant.
- Changes to the owner's inputs after the grant are ignored.
- A non-owner request waits; there is no starvation, because its wait is bounded by one transaction.
- A write transaction leaves that master's rdata register unchanged.
- Counter width is `$clog2(LAT)` with a minimum of 1. There is no other arithmetic.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_en`, `mem_we`, `m0_ready`, `m1_ready` = 0.
  - `grant` = 00.
  - `mem_addr`, `mem_wdata`, `m0_rdata`, `m1_rdata` = 0.
  - `last` = 1.
- Reset asserted mid-transaction aborts it immediately (asynchronous): `mem_en`/`mem_we` drop without waiting for a clock, and no ready pulse is issued.
- Latency: `req` sampled in IDLE at edge N → ACCESS in cycles N+1 … N+LAT → `ready` high in cycle N+LAT+1.
- Throughput: one IDLE cycle between transactions, so at most one transaction per `LAT+2` cycles.
- All outputs are registered or decoded from state only; no combinational path from `req` to `ready`.

## Structure
- Package `mio_arb_pkg`: state encoding localparams (IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10) and the grant encodings.
- Sub-module `rr_pick2`: combinational 2-way round-robin selector (inputs `req[1:0]`, `last`; output one-hot `pick`). Everything else lives in `mio_arbiter`.

## Test plan
All scenarios use `LAT` = 2.
- **CPU read:** m0 read of 0x0000_0010 with memory returning 0xDEAD_BEEF → `mem_en` high 2 cycles, `m0_ready` pulses 3 cycles after the request is sampled, `m0_rdata` = 0xDEAD_BEEF; `m1_ready` stays 0.
- **m1 write:** m1 write of 0xA5A5_A5A5 to 0x0000_0100 → `mem_we` = 1 for exactly 2 cycles with a stable addr/data; `m1_ready` pulses once; `m1_rdata` unchanged.
- **Simultaneous and back-to-back requests:** both masters request continuously from reset → grants alternate m0, m1, m0, m1; each transaction is 4 cycles apart.
- **Input change after grant:** m0 changes `m0_addr` from 0x4 to 0x8 during ACCESS → `mem_addr` stays 0x4.
- **Reset mid-transaction:** reset asserted in the first ACCESS cycle → `mem_en`/`mem_we` drop before the next edge; no ready pulse; after release, a pending m1 request is served normally.

Source files
------------

// File: rtl/mio_arb_pkg.sv
// Shared encodings for the two-master memory/IO arbiter: FSM states and grant vectors.
package mio_arb_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'b00;
    localparam logic [1:0] ST_ACCESS_ENC = 2'b01;
    localparam logic [1:0] ST_RESP_ENC   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_ACCESS = ST_ACCESS_ENC,
        ST_RESP   = ST_RESP_ENC
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Owner bit (0 = m0, 1 = m1) to one-hot grant.
    function automatic logic [1:0] owner_grant(input logic owner);
        return owner ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/mio_arbiter_if.sv
// Request/response bundle between one bus master and the arbiter.
interface mio_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mio_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to the
// master that was not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // Tie-break on last owner; otherwise pass the request through.
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

// File: rtl/mio_arbiter.sv
// Shares one fixed-latency memory port between two masters: latch winner,
// hold the port for LAT cycles, register read data, pulse ready once.
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mio_arbiter_if.slave  m0,
    mio_arbiter_if.slave  m1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant
);

    localparam int             CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LAT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [1:0]    pick_s;

    rr_pick2 u_pick (
        .req  ({m1.req, m0.req}),
        .last (last_q),
        .pick (pick_s)
    );

    // Next-state and datapath latching; requests only matter in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s != 2'b00) begin
                    state_d = ST_ACCESS;
                    owner_d = pick_s[1];
                    last_d  = pick_s[1];
                    we_d    = pick_s[1] ? m1.we    : m0.we;
                    addr_d  = pick_s[1] ? m1.addr  : m0.addr;
                    wdata_d = pick_s[1] ? m1.wdata : m0.wdata;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (!we_q && owner_q) begin
                        rdata1_d = mem_rdata;
                    end else if (!we_q) begin
                        rdata0_d = mem_rdata;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = (state_q == ST_IDLE) ? GNT_NONE : owner_grant(owner_q);
    assign m0.ready  = (state_q == ST_RESP) & ~owner_q;
    assign m1.ready  = (state_q == ST_RESP) & owner_q;
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter (LAT = 2): cycle-by-cycle vector table plus
// hand sequences for late address changes and reset mid-transaction.
module tb_mio_arbiter;

    logic        clk;
    logic        reset;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;
    int          total;
    int          bad;

    mio_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    mio_arbiter_if #(.AW(32), .DW(32)) m1_if ();

    mio_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [31:0] mrd;
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_gnt;
        logic        e_rdy0, e_rdy1;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic [31:0] mrd,
        input logic en, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [1:0] gnt, input logic rdy0, input logic rdy1,
        input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.mrd = mrd;
        v.e_en = en; v.e_we = we; v.e_addr = addr; v.e_wdata = wdata;
        v.e_gnt = gnt; v.e_rdy0 = rdy0; v.e_rdy1 = rdy1;
        v.e_rd0 = rd0; v.e_rd1 = rd1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("v%0d mem_en", i),    {31'd0, mem_en},         {31'd0, v.e_en});
        check($sformatf("v%0d mem_we", i),    {31'd0, mem_we},         {31'd0, v.e_we});
        check($sformatf("v%0d mem_addr", i),  mem_addr,                v.e_addr);
        check($sformatf("v%0d mem_wdata", i), mem_wdata,               v.e_wdata);
        check($sformatf("v%0d grant", i),     {30'd0, grant},          {30'd0, v.e_gnt});
        check($sformatf("v%0d m0_ready", i),  {31'd0, m0_if.ready},    {31'd0, v.e_rdy0});
        check($sformatf("v%0d m1_ready", i),  {31'd0, m1_if.ready},    {31'd0, v.e_rdy1});
        check($sformatf("v%0d m0_rdata", i),  m0_if.rdata,             v.e_rd0);
        check($sformatf("v%0d m1_rdata", i),  m1_if.rdata,             v.e_rd1);
    endtask

    task automatic drive(input vec_t v);
        m0_if.req = v.r0; m0_if.we = v.w0; m0_if.addr = v.a0; m0_if.wdata = v.d0;
        m1_if.req = v.r1; m1_if.we = v.w1; m1_if.addr = v.a1; m1_if.wdata = v.d1;
        mem_rdata = v.mrd;
    endtask

    initial begin
        logic [31:0] A5;
        logic [31:0] DB;
        int          waited;
        logic        seen;
        total = 0;
        bad   = 0;
        A5 = 32'hA5A5_A5A5;
        DB = 32'hDEAD_BEEF;

        //              r0  w0  a0      d0     r1  w1  a1       d1  mrd            en  we  addr     wdata  gnt    rd0 rd1 m0_rdata      m1_rdata
        tbl[0]  = mk(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,  A5, DB,           1'b1,1'b0,32'h10, 32'h0, 2'b01,1'b0,1'b0,32'h0, 32'h0);
        tbl[1]  = mk(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,  A5, DB,           1'b1,1'b0,32'h10, 32'h0, 2'b01,1'b0,1'b0,32'h0, 32'h0);
        tbl[2]  = mk(1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,  A5, DB,           1'b0,1'b0,32'h10, 32'h0, 2'b01,1'b1,1'b0,DB,    32'h0);
        tbl[3]  = mk(1'b0,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,  A5, DB,           1'b0,1'b0,32'h10, 32'h0, 2'b00,1'b0,1'b0,DB,    32'h0);
        tbl[4]  = mk(1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h100,A5, 32'h1111_1111,1'b1,1'b1,32'h100,A5,    2'b10,1'b0,1'b0,DB,    32'h0);
        tbl[5]  = mk(1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h100,A5, 32'h1111_1111,1'b1,1'b1,32'h100,A5,    2'b10,1'b0,1'b0,DB,    32'h0);
        tbl[6]  = mk(1'b0,1'b0,32'h10,32'h0, 1'b1,1'b1,32'h100,A5, 32'h1111_1111,1'b0,1'b0,32'h100,A5,    2'b10,1'b0,1'b1,DB,    32'h0);
        tbl[7]  = mk(1'b0,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h100,A5, 32'h1111_1111,1'b0,1'b0,32'h100,A5,    2'b00,1'b0,1'b0,DB,    32'h0);
        tbl[8]  = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hA0,       1'b1,1'b0,32'h20, 32'h0, 2'b01,1'b0,1'b0,DB,    32'h0);
        tbl[9]  = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hA0,       1'b1,1'b0,32'h20, 32'h0, 2'b01,1'b0,1'b0,DB,    32'h0);
        tbl[10] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hA0,       1'b0,1'b0,32'h20, 32'h0, 2'b01,1'b1,1'b0,32'hA0,32'h0);
        tbl[11] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hA0,       1'b0,1'b0,32'h20, 32'h0, 2'b00,1'b0,1'b0,32'hA0,32'h0);
        tbl[12] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hB0,       1'b1,1'b0,32'h30, A5,    2'b10,1'b0,1'b0,32'hA0,32'h0);
        tbl[13] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hB0,       1'b1,1'b0,32'h30, A5,    2'b10,1'b0,1'b0,32'hA0,32'h0);
        tbl[14] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hB0,       1'b0,1'b0,32'h30, A5,    2'b10,1'b0,1'b1,32'hA0,32'hB0);
        tbl[15] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hB0,       1'b0,1'b0,32'h30, A5,    2'b00,1'b0,1'b0,32'hA0,32'hB0);
        tbl[16] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hC0,       1'b1,1'b0,32'h20, 32'h0, 2'b01,1'b0,1'b0,32'hA0,32'hB0);
        tbl[17] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hC0,       1'b1,1'b0,32'h20, 32'h0, 2'b01,1'b0,1'b0,32'hA0,32'hB0);
        tbl[18] = mk(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h30, A5, 32'hC0,       1'b0,1'b0,32'h20, 32'h0, 2'b01,1'b1,1'b0,32'hC0,32'hB0);
        tbl[19] = mk(1'b0,1'b0,32'h20,32'h0, 1'b0,1'b0,32'h30, A5, 32'hC0,       1'b0,1'b0,32'h20, 32'h0, 2'b00,1'b0,1'b0,32'hC0,32'hB0);

        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
        mem_rdata = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst mem_en",   {31'd0, mem_en},      32'h0);
        check("rst mem_we",   {31'd0, mem_we},      32'h0);
        check("rst grant",    {30'd0, grant},       32'h0);
        check("rst mem_addr", mem_addr,             32'h0);
        check("rst m0_ready", {31'd0, m0_if.ready}, 32'h0);
        check("rst m1_ready", {31'd0, m1_if.ready}, 32'h0);
        check("rst m0_rdata", m0_if.rdata,          32'h0);
        check("rst m1_rdata", m1_if.rdata,          32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_vec(i, tbl[i]);
        end

        // Address change after grant must not reach the memory port.
        @(negedge clk);
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h4; mem_rdata = 32'h44;
        @(posedge clk); #1;
        check("chg grant", {30'd0, grant}, 32'h1);
        check("chg addr0", mem_addr, 32'h4);
        @(negedge clk);
        m0_if.addr = 32'h8;
        @(posedge clk); #1;
        check("chg addr1", mem_addr, 32'h4);
        check("chg en1", {31'd0, mem_en}, 32'h1);
        @(posedge clk); #1;
        check("chg rdy", {31'd0, m0_if.ready}, 32'h1);
        check("chg rdata", m0_if.rdata, 32'h44);
        @(negedge clk);
        m0_if.req = 1'b0;
        @(posedge clk); #1;
        check("chg idle", {30'd0, grant}, 32'h0);

        // Reset during the first ACCESS cycle of an m1 write.
        @(negedge clk);
        m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h200; m1_if.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        check("rst_mid en",  {31'd0, mem_en}, 32'h1);
        check("rst_mid we",  {31'd0, mem_we}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid en_drop", {31'd0, mem_en}, 32'h0);
        check("rst_mid we_drop", {31'd0, mem_we}, 32'h0);
        check("rst_mid gnt",     {30'd0, grant},  32'h0);
        @(posedge clk); #1;
        check("rst_mid rdy1", {31'd0, m1_if.ready}, 32'h0);
        check("rst_mid rd0",  m0_if.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 10) begin
            @(posedge clk); #1;
            waited = waited + 1;
            if (waited == 1) begin
                check("post_rst gnt",  {30'd0, grant}, 32'h2);
                check("post_rst addr", mem_addr, 32'h200);
            end
            if (m1_if.ready) begin
                seen = 1'b1;
            end else begin
                seen = 1'b0;
            end
        end
        check("post_rst seen",    {31'd0, seen}, 32'h1);
        check("post_rst latency", waited, 32'd3);
        check("post_rst rd1",     m1_if.rdata, 32'h0);
        @(negedge clk);
        m1_if.req = 1'b0;
        @(posedge clk); #1;
        check("post_rst idle", {31'd0, mem_en}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
